// File: rtl/ahb2apb_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahb2apb_reset_ctrl
// Brief    : Reset sequencer for the ahb2apb bridge (POR / SW / WDT sources,
//            staggered APB-then-AHB release, idle drain before a SW reset).
// Revision : 1.0 - initial release
// ============================================================================
module ahb2apb_reset_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYC      = 8,
    parameter int STAGGER_CYC   = 4,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sw_rst_req,
    input  logic       wdt_rst_req,
    input  logic       bridge_idle,
    output logic       hresetn_o,
    output logic       presetn_o,
    output logic       rst_busy,
    output logic [1:0] rst_cause,
    output logic       drain_timeout
);

    localparam int MAX_HS  = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC : STAGGER_CYC;
    localparam int MAX_CNT = (MAX_HS > DRAIN_TIMEOUT) ? MAX_HS : DRAIN_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_APB_REL = 3'd2,
        ST_RUN     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_ASSERT  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             cause_q, cause_d;
    logic                   dto_q, dto_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hresetn_q, presetn_q, busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        dto_d   = dto_q;
        case (state_q)
            ST_SYNC: begin
                // The cycle in which the synchronizer first reads 1 is already
                // the first hold cycle, so the count starts at one.
                if (sync_q[SYNC_STAGES-1]) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_HOLD, ST_ASSERT: begin
                if (cnt_q >= HOLD_LAST) begin
                    state_d = ST_APB_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_APB_REL: begin
                if (cnt_q >= STAG_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (wdt_rst_req) begin
                    state_d = ST_ASSERT;
                    cause_d = CAUSE_WDT;
                end else if (sw_rst_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wdt_rst_req) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    cause_d = CAUSE_WDT;
                end else if (bridge_idle) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    cause_d = CAUSE_SW;
                    dto_d   = 1'b0;
                end else if (cnt_q >= DRAIN_LAST) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    cause_d = CAUSE_SW;
                    dto_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_SYNC;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register, without combinational glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_SYNC;
            cnt_q     <= '0;
            cause_q   <= CAUSE_POR;
            dto_q     <= 1'b0;
            hresetn_q <= 1'b0;
            presetn_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            dto_q     <= dto_d;
            hresetn_q <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            presetn_q <= (state_d == ST_RUN) || (state_d == ST_DRAIN) ||
                         (state_d == ST_APB_REL);
            busy_q    <= (state_d != ST_RUN);
        end
    end

    assign hresetn_o     = hresetn_q;
    assign presetn_o     = presetn_q;
    assign rst_busy      = busy_q;
    assign rst_cause     = cause_q;
    assign drain_timeout = dto_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb2apb_reset_ctrl
// Brief    : Directed self-checking bench with a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb2apb_reset_ctrl;

    localparam int SYNC_STAGES   = 2;
    localparam int HOLD_CYC      = 8;
    localparam int STAGGER_CYC   = 4;
    localparam int DRAIN_TIMEOUT = 64;

    logic       clk         = 1'b0;
    logic       reset_n     = 1'b0;
    logic       sw_rst_req  = 1'b0;
    logic       wdt_rst_req = 1'b0;
    logic       bridge_idle = 1'b0;
    logic       hresetn_o;
    logic       presetn_o;
    logic       rst_busy;
    logic [1:0] rst_cause;
    logic       drain_timeout;

    int checks   = 0;
    int failures = 0;

    ahb2apb_reset_ctrl #(
        .SYNC_STAGES  (SYNC_STAGES),
        .HOLD_CYC     (HOLD_CYC),
        .STAGGER_CYC  (STAGGER_CYC),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw_rst_req   (sw_rst_req),
        .wdt_rst_req  (wdt_rst_req),
        .bridge_idle  (bridge_idle),
        .hresetn_o    (hresetn_o),
        .presetn_o    (presetn_o),
        .rst_busy     (rst_busy),
        .rst_cause    (rst_cause),
        .drain_timeout(drain_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges counted since reset_n release; release instants kept as
    // absolute edge numbers and moved forward whenever a reset fires.
    int m_k     = 0;
    int m_prel  = SYNC_STAGES + HOLD_CYC;
    int m_hrel  = SYNC_STAGES + HOLD_CYC + STAGGER_CYC;
    int m_drain = -1;
    int m_cause = 0;
    int m_dto   = 0;

    always @(posedge clk) begin
        int prev;
        bit exp_p, exp_h;
        #1;
        if (!reset_n) begin
            m_k     = 0;
            m_prel  = SYNC_STAGES + HOLD_CYC;
            m_hrel  = SYNC_STAGES + HOLD_CYC + STAGGER_CYC;
            m_drain = -1;
            m_cause = 0;
            m_dto   = 0;
        end else begin
            prev = m_k;
            m_k  = m_k + 1;
            if (prev >= m_hrel) begin
                if (wdt_rst_req) begin
                    m_cause = 2;
                    m_drain = -1;
                    m_prel  = m_k + HOLD_CYC;
                    m_hrel  = m_prel + STAGGER_CYC;
                end else if (m_drain < 0) begin
                    if (sw_rst_req) m_drain = m_k;
                end else if (bridge_idle || (m_k - m_drain == DRAIN_TIMEOUT)) begin
                    m_dto   = bridge_idle ? 0 : 1;
                    m_cause = 1;
                    m_drain = -1;
                    m_prel  = m_k + HOLD_CYC;
                    m_hrel  = m_prel + STAGGER_CYC;
                end
            end
        end
        exp_p = (m_k >= m_prel);
        exp_h = (m_k >= m_hrel);
        check("model_presetn", int'(presetn_o), int'(exp_p));
        check("model_hresetn", int'(hresetn_o), int'(exp_h));
        check("model_busy", int'(rst_busy), int'(!(exp_h && m_drain < 0)));
        check("model_cause", int'(rst_cause), m_cause);
        check("model_dto", int'(drain_timeout), m_dto);
        check("order", int'((hresetn_o && !presetn_o) ||
                            (presetn_o && !hresetn_o && !(exp_p && !exp_h))), 0);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sw_pulse();
        @(negedge clk) sw_rst_req = 1'b1;
        @(negedge clk) sw_rst_req = 1'b0;
    endtask

    task automatic power_on_timing(input string tag);
        cyc(9);
        check({tag, "_p_e9"}, int'(presetn_o), 0);
        cyc(1);
        check({tag, "_p_e10"}, int'(presetn_o), 1);
        check({tag, "_h_e10"}, int'(hresetn_o), 0);
        cyc(3);
        check({tag, "_h_e13"}, int'(hresetn_o), 0);
        cyc(1);
        check({tag, "_h_e14"}, int'(hresetn_o), 1);
        check({tag, "_busy_e14"}, int'(rst_busy), 0);
        check({tag, "_cause"}, int'(rst_cause), 0);
    endtask

    initial begin
        // Power-on
        repeat (5) @(negedge clk);
        check("por_presetn", int'(presetn_o), 0);
        check("por_hresetn", int'(hresetn_o), 0);
        check("por_busy", int'(rst_busy), 1);
        check("por_cause", int'(rst_cause), 0);
        check("por_dto", int'(drain_timeout), 0);
        reset_n = 1'b1;
        power_on_timing("por");

        // Software reset, bridge never idle: forced after the drain timeout
        sw_pulse();
        cyc(63);
        check("to_p_drain63", int'(presetn_o), 1);
        check("to_h_drain63", int'(hresetn_o), 1);
        check("to_busy_drain63", int'(rst_busy), 1);
        cyc(1);
        check("to_p_assert", int'(presetn_o), 0);
        check("to_dto", int'(drain_timeout), 1);
        check("to_cause", int'(rst_cause), 1);
        @(negedge clk);
        cyc(11);
        check("to_h_a11", int'(hresetn_o), 0);
        cyc(1);
        check("to_h_a12", int'(hresetn_o), 1);
        check("to_dto_run", int'(drain_timeout), 1);

        // Watchdog preempts a drain on its tenth cycle
        sw_pulse();
        repeat (9) @(negedge clk);
        wdt_rst_req = 1'b1;
        cyc(1);
        check("wdtp_p", int'(presetn_o), 0);
        check("wdtp_cause", int'(rst_cause), 2);
        check("wdtp_dto_kept", int'(drain_timeout), 1);
        @(negedge clk) wdt_rst_req = 1'b0;
        cyc(12);
        check("wdtp_h_rel", int'(hresetn_o), 1);

        // Software reset drained by idle after 3 cycles clears the timeout flag
        sw_pulse();
        repeat (2) @(negedge clk);
        bridge_idle = 1'b1;
        cyc(1);
        check("sw_p", int'(presetn_o), 0);
        check("sw_h", int'(hresetn_o), 0);
        check("sw_cause", int'(rst_cause), 1);
        check("sw_dto", int'(drain_timeout), 0);
        @(negedge clk) bridge_idle = 1'b0;
        cyc(7);
        check("sw_p_a7", int'(presetn_o), 0);
        cyc(1);
        check("sw_p_a8", int'(presetn_o), 1);
        check("sw_h_a8", int'(hresetn_o), 0);
        cyc(4);
        check("sw_h_a12", int'(hresetn_o), 1);

        // wdt and sw together in RUN; wdt held to show level retrigger
        @(negedge clk) begin
            sw_rst_req  = 1'b1;
            wdt_rst_req = 1'b1;
        end
        cyc(1);
        check("both_p", int'(presetn_o), 0);
        check("both_cause", int'(rst_cause), 2);
        @(negedge clk) sw_rst_req = 1'b0;
        cyc(11);
        cyc(1);
        check("retrig_h_run", int'(hresetn_o), 1);
        cyc(1);
        check("retrig_h_again", int'(hresetn_o), 0);
        @(negedge clk) wdt_rst_req = 1'b0;

        // Abort inside APB_REL
        repeat (8) @(negedge clk);
        check("abort_apb_pre_p", int'(presetn_o), 1);
        check("abort_apb_pre_h", int'(hresetn_o), 0);
        reset_n = 1'b0;
        #1;
        check("abort_apb_p", int'(presetn_o), 0);
        check("abort_apb_cause", int'(rst_cause), 0);
        check("abort_apb_busy", int'(rst_busy), 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        power_on_timing("abort_apb");

        // Abort inside DRAIN
        sw_pulse();
        repeat (4) @(negedge clk);
        check("abort_drain_pre_h", int'(hresetn_o), 1);
        check("abort_drain_pre_busy", int'(rst_busy), 1);
        reset_n = 1'b0;
        #1;
        check("abort_drain_h", int'(hresetn_o), 0);
        check("abort_drain_p", int'(presetn_o), 0);
        check("abort_drain_cause", int'(rst_cause), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        power_on_timing("abort_drain");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
